fpu_ss_result_fifo: RTL and testbench

FPU_SS_RESULT_FIFO -- requirements
Module: fpu_ss_result_fifo

---
 rtl/fpu_ss_pkg.sv | 21 ++
 rtl/fpu_ss_result_fifo.sv | 98 +++++++++
 tb/tb_fpu_ss_result_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared FPU subsystem types and constants.
// Includes the result FIFO depth, the core ID width and the result FIFO entry layout.
package fpu_ss_pkg;

  localparam int RESULT_FIFO_DEPTH = 4;
  localparam int CORE_ID_W         = 32;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } x_result_t;

  // One FIFO slot: the result payload travels together with its destination core.
  typedef struct packed {
    x_result_t              result;
    logic [CORE_ID_W-1:0]   destId;
  } result_entry_t;

endpackage

// File: rtl/fpu_ss_result_fifo.sv
// Result FIFO between the FPU subsystem and the cores, with one cycle of latency.
// Optional statistics counters are enabled by defining FPU_SS_RESULT_FIFO_STATS_EN.
module fpu_ss_result_fifo
  import fpu_ss_pkg::*;
#(
  parameter int DEPTH    = RESULT_FIFO_DEPTH,
  parameter int NB_CORES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 x_result_valid_i,
  output logic                 x_result_ready_o,
  input  x_result_t            x_result_i,
  input  logic [CORE_ID_W-1:0] dest_core_id_i,
  output logic                 x_result_valid_o,
  input  logic                 x_result_ready_i,
  output x_result_t            x_result_o,
  output logic [CORE_ID_W-1:0] dest_core_id_o,
  output logic                 dest_err_o
`ifdef FPU_SS_RESULT_FIFO_STATS_EN
  ,
  output logic [31:0]          stat_pushed_o,
  output logic [31:0]          stat_full_cycles_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  result_entry_t    r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Reset takes priority, so neither push nor pop may happen in a reset cycle.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = x_result_valid_i && !w_full && !rst_i;
  assign w_pop   = x_result_ready_i && !w_empty && !rst_i;

  assign x_result_ready_o = !w_full;
  assign x_result_valid_o = !w_empty;
  assign x_result_o       = r_mem[r_rdPtr].result;
  assign dest_core_id_o   = r_mem[r_rdPtr].destId;
  assign dest_err_o       = w_push && (dest_core_id_i >= CORE_ID_W'(NB_CORES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= '{result: x_result_i, destId: dest_core_id_i};
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FPU_SS_RESULT_FIFO_STATS_EN
  logic [31:0] r_statPushed;
  logic [31:0] r_statFullCycles;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_statPushed     <= '0;
      r_statFullCycles <= '0;
    end else begin
      if (w_push) begin
        r_statPushed <= r_statPushed + 32'd1;
      end
      if (x_result_valid_i && w_full) begin
        r_statFullCycles <= r_statFullCycles + 32'd1;
      end
    end
  end

  assign stat_pushed_o      = r_statPushed;
  assign stat_full_cycles_o = r_statFullCycles;
`endif

endmodule

// File: tb/tb_fpu_ss_result_fifo.sv
// Self-checking bench for fpu_ss_result_fifo: vector table plus directed multi-cycle sequences.
// Statistics ports are checked when FPU_SS_RESULT_FIFO_STATS_EN is defined.
module tb_fpu_ss_result_fifo;
  import fpu_ss_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  x_result_t   x_result_i;
  logic [31:0] dest_core_id_i;
  logic        x_result_valid_o;
  logic        x_result_ready_i;
  x_result_t   x_result_o;
  logic [31:0] dest_core_id_o;
  logic        dest_err_o;
`ifdef FPU_SS_RESULT_FIFO_STATS_EN
  logic [31:0] stat_pushed_o;
  logic [31:0] stat_full_cycles_o;
`endif

  int checks = 0;
  int errors = 0;

  fpu_ss_result_fifo #(.DEPTH(4), .NB_CORES(8)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_i       (x_result_i),
    .dest_core_id_i   (dest_core_id_i),
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_o       (x_result_o),
    .dest_core_id_o   (dest_core_id_o),
    .dest_err_o       (dest_err_o)
`ifdef FPU_SS_RESULT_FIFO_STATS_EN
    ,
    .stat_pushed_o      (stat_pushed_o),
    .stat_full_cycles_o (stat_full_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        valid;
    logic        rdy;
    logic [3:0]  id;
    logic [31:0] dest;
    logic        chkHead;
    logic        expValid;
    logic        expReady;
    logic [3:0]  expId;
    logic [31:0] expDest;
    logic        expErr;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rdy, input logic [3:0] id,
                               input logic [31:0] dest, input logic rst);
    rst_i            = rst;
    x_result_valid_i = valid;
    x_result_ready_i = rdy;
    x_result_i       = '{id: id, data: {28'hA5A5_A5A, id}, rd: {1'b0, id}, we: 1'b1};
    dest_core_id_i   = dest;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mkVec(string name, logic valid, logic rdy, logic [3:0] id,
                                 logic [31:0] dest, logic chkHead, logic expValid,
                                 logic expReady, logic [3:0] expId, logic [31:0] expDest,
                                 logic expErr);
    vec_t v;
    v.name = name; v.valid = valid; v.rdy = rdy; v.id = id; v.dest = dest;
    v.chkHead = chkHead; v.expValid = expValid; v.expReady = expReady;
    v.expId = expId; v.expDest = expDest; v.expErr = expErr;
    return v;
  endfunction

  int q[$];
  int sent;
  int got;
  logic expValid;
  logic expReady;
  logic doPush;
  logic doPop;
  logic rdy;

  initial begin
    // Expectations describe outputs seen during the cycle, before the closing edge.
    vecs[0]  = mkVec("reset_state",   0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    vecs[1]  = mkVec("lat_push",      1, 1, 3, 2, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mkVec("lat_head",      0, 1, 0, 0, 1, 1, 1, 3, 2, 0);
    vecs[3]  = mkVec("lat_empty",     0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    vecs[4]  = mkVec("bad_push",      1, 0, 5, 8, 0, 0, 1, 0, 0, 1);
    vecs[5]  = mkVec("bad_head",      0, 0, 0, 0, 1, 1, 1, 5, 8, 0);
    vecs[6]  = mkVec("bad_pop",       0, 1, 0, 0, 1, 1, 1, 5, 8, 0);
    vecs[7]  = mkVec("bad_empty",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mkVec("edge_push",     1, 0, 7, 7, 0, 0, 1, 0, 0, 0);
    vecs[9]  = mkVec("edge_head",     0, 1, 0, 0, 1, 1, 1, 7, 7, 0);
    vecs[10] = mkVec("edge_empty",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 1);
    step();
    step();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].rdy, vecs[i].id, vecs[i].dest, 0);
      #1;
      checkOutput({vecs[i].name, "_valid"}, 32'(x_result_valid_o), 32'(vecs[i].expValid));
      checkOutput({vecs[i].name, "_ready"}, 32'(x_result_ready_o), 32'(vecs[i].expReady));
      checkOutput({vecs[i].name, "_err"},   32'(dest_err_o),       32'(vecs[i].expErr));
      if (vecs[i].chkHead) begin
        checkOutput({vecs[i].name, "_id"},   32'(x_result_o.id), 32'(vecs[i].expId));
        checkOutput({vecs[i].name, "_dest"}, dest_core_id_o,     vecs[i].expDest);
      end
      @(posedge clk_i);
      #1;
    end

    // Reset with three entries held; the offer during reset must not be stored.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 4'(i), 32'(i), 0);
      step();
    end
    applyStimulus(1, 1, 6, 9, 1);
    #1;
    checkOutput("rst_err_low", 32'(dest_err_o), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_valid", 32'(x_result_valid_o), 0);
    checkOutput("rst_ready", 32'(x_result_ready_o), 1);
    checkOutput("rst_dest",  dest_core_id_o, 0);
    checkOutput("rst_id",    32'(x_result_o.id), 0);
`ifdef FPU_SS_RESULT_FIFO_STATS_EN
    checkOutput("rst_stat_pushed", stat_pushed_o, 0);
    checkOutput("rst_stat_full",   stat_full_cycles_o, 0);
`endif
    step();
    #1;
    checkOutput("rst_still_empty", 32'(x_result_valid_o), 0);

    // Fill to full with the consumer stalled, then offer a fifth while popping.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 4'(i), 32'(i), 0);
      #1;
      checkOutput($sformatf("full_ready_%0d", i), 32'(x_result_ready_o), 1);
      step();
    end
    applyStimulus(1, 1, 4, 4, 0);
    #1;
    checkOutput("full_ready_low", 32'(x_result_ready_o), 0);
    checkOutput("full_head_id",   32'(x_result_o.id), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("full_ready_rise", 32'(x_result_ready_o), 1);
`ifdef FPU_SS_RESULT_FIFO_STATS_EN
    checkOutput("full_stat_pushed", stat_pushed_o, 4);
    checkOutput("full_stat_full",   stat_full_cycles_o, 1);
`endif
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      #1;
      checkOutput($sformatf("drain_valid_%0d", i), 32'(x_result_valid_o), 1);
      checkOutput($sformatf("drain_id_%0d", i),    32'(x_result_o.id), 32'(i));
      step();
    end
    #1;
    checkOutput("drain_empty", 32'(x_result_valid_o), 0);

    // Head must hold steady through a five-cycle stall.
    applyStimulus(1, 0, 9, 4, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput($sformatf("stall_valid_%0d", i), 32'(x_result_valid_o), 1);
      checkOutput($sformatf("stall_id_%0d", i),    32'(x_result_o.id), 9);
      checkOutput($sformatf("stall_dest_%0d", i),  dest_core_id_o, 4);
      step();
    end
    applyStimulus(0, 1, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("stall_popped", 32'(x_result_valid_o), 0);

    // Stream ten entries against a reference queue with the consumer toggling.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      rdy = cyc[0];
      applyStimulus(sent < 10, rdy, 4'(sent), 32'(sent), 0);
      #1;
      expValid = q.size() > 0;
      expReady = q.size() < 4;
      checkOutput("wrap_valid", 32'(x_result_valid_o), 32'(expValid));
      checkOutput("wrap_ready", 32'(x_result_ready_o), 32'(expReady));
      if (expValid) begin
        checkOutput($sformatf("wrap_id_%0d", got),   32'(x_result_o.id), 32'(q[0]));
        checkOutput($sformatf("wrap_dest_%0d", got), dest_core_id_o,     32'(q[0]));
      end
      doPush = (sent < 10) && expReady;
      doPop  = expValid && rdy;
      step();
      if (doPop) begin
        void'(q.pop_front());
        got++;
      end
      if (doPush) begin
        q.push_back(sent);
        sent++;
      end
    end
    checkOutput("wrap_count", 32'(got), 10);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("wrap_empty", 32'(x_result_valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
